// File: rtl/vec_instr_sequencer.sv
// ---------------------------------------------------------------------------
// vec_instr_sequencer
//
// Fetches instructions from a synchronous program memory and issues them to
// the CPU_vector instruction port one at a time. Multi-cycle vector ops
// (MULFV, SUMFV) park the sequencer in WAIT with NOP on the port until the
// datapath pulses vec_done_i. A watchdog aborts a WAIT that outlives
// WAIT_TIMEOUT cycles and leaves a sticky error flag.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          asynchronous reset, active-high
//   start_i        pulse: begin execution at address 0 (from IDLE or HALTED)
//   imem_addr_o    program memory read address (memory has 1-cycle latency)
//   imem_data_i    program memory read data
//   instr_o        instruction to CPU_vector (NOP whenever instr_valid_o=0)
//   instr_valid_o  high exactly on the cycle an issued instruction is on instr_o
//   pc_o           address of the most recently issued instruction
//   vec_done_i     pulse: current MULFV/SUMFV finished (honoured in WAIT only)
//   busy_o         high in FETCH, ISSUE, WAIT
//   halted_o       high in HALTED
//   timeout_err_o  sticky WAIT-timeout flag, cleared by start_i or rst_i
// ---------------------------------------------------------------------------
module vec_instr_sequencer #(
    parameter int INSTR_W      = 30,
    parameter int PC_W         = 32,
    parameter int IMEM_AW      = 8,
    parameter int WAIT_TIMEOUT = 1023
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    output logic [IMEM_AW-1:0] imem_addr_o,
    input  logic [INSTR_W-1:0] imem_data_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic               instr_valid_o,
    output logic [PC_W-1:0]    pc_o,
    input  logic               vec_done_i,
    output logic               busy_o,
    output logic               halted_o,
    output logic               timeout_err_o
);

    localparam int CNT_W = $clog2(WAIT_TIMEOUT + 1);

    localparam logic [3:0] OP_SUMFV = 4'b0011;
    localparam logic [3:0] OP_MULFV = 4'b0100;
    localparam logic [3:0] OP_NOP   = 4'b0101;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    localparam logic [INSTR_W-1:0] NOP_WORD  = {OP_NOP, {(INSTR_W-4){1'b0}}};
    localparam logic [IMEM_AW-1:0] ADDR_ZERO = {IMEM_AW{1'b0}};
    localparam logic [IMEM_AW-1:0] ADDR_ONE  = {{(IMEM_AW-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_LIMIT = CNT_W'(WAIT_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_HALTED = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [IMEM_AW-1:0] fetch_addr_q, fetch_addr_d;
    logic [IMEM_AW-1:0] imem_addr_q, imem_addr_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               instr_valid_q, instr_valid_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               busy_q, busy_d;
    logic               halted_q, halted_d;
    logic               timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;

    logic [3:0]         opcode_s;
    logic               is_vec_op_s;
    logic [CNT_W-1:0]   wait_cnt_inc_s;
    logic               timeout_hit_s;

    // Opcode decode of the word the memory returns during ISSUE, plus the
    // watchdog compare: the abort fires on the WAIT cycle whose increment
    // reaches the limit, so WAIT lasts at most WAIT_TIMEOUT cycles.
    always_comb begin
        opcode_s       = imem_data_i[INSTR_W-1 -: 4];
        is_vec_op_s    = (opcode_s == OP_MULFV) || (opcode_s == OP_SUMFV);
        wait_cnt_inc_s = wait_cnt_q + CNT_ONE;
        timeout_hit_s  = (wait_cnt_inc_s == CNT_LIMIT);
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. vec_done wins over a coincident timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_FETCH;
                else         state_d = S_IDLE;
            end
            S_FETCH: state_d = S_ISSUE;
            S_ISSUE: begin
                if (is_vec_op_s)              state_d = S_WAIT;
                else if (opcode_s == OP_HALT) state_d = S_HALTED;
                else                          state_d = S_FETCH;
            end
            S_WAIT: begin
                if (vec_done_i)         state_d = S_FETCH;
                else if (timeout_hit_s) state_d = S_HALTED;
                else                    state_d = S_WAIT;
            end
            S_HALTED: begin
                if (start_i) state_d = S_FETCH;
                else         state_d = S_HALTED;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values. The port carries NOP unless this very
    // transition is the issue of a fetched word.
    always_comb begin
        fetch_addr_d  = fetch_addr_q;
        imem_addr_d   = imem_addr_q;
        instr_d       = NOP_WORD;
        instr_valid_d = 1'b0;
        pc_d          = pc_q;
        timeout_err_d = timeout_err_q;
        wait_cnt_d    = wait_cnt_q;
        case (state_q)
            S_IDLE, S_HALTED: begin
                if (start_i) begin
                    fetch_addr_d  = ADDR_ZERO;
                    imem_addr_d   = ADDR_ZERO;
                    timeout_err_d = 1'b0;
                end else begin
                    fetch_addr_d  = fetch_addr_q;
                end
            end
            S_FETCH: begin
                wait_cnt_d = wait_cnt_q;
            end
            S_ISSUE: begin
                instr_d       = imem_data_i;
                instr_valid_d = 1'b1;
                pc_d          = PC_W'(fetch_addr_q);
                // IMEM_AW-bit add wraps from the last word back to 0.
                fetch_addr_d  = fetch_addr_q + ADDR_ONE;
                imem_addr_d   = fetch_addr_q + ADDR_ONE;
                wait_cnt_d    = CNT_ZERO;
            end
            S_WAIT: begin
                if (vec_done_i) begin
                    wait_cnt_d = wait_cnt_q;
                end else begin
                    wait_cnt_d = wait_cnt_inc_s;
                    if (timeout_hit_s) timeout_err_d = 1'b1;
                    else               timeout_err_d = timeout_err_q;
                end
            end
            default: begin
                fetch_addr_d = fetch_addr_q;
            end
        endcase
        busy_d   = (state_d == S_FETCH) || (state_d == S_ISSUE) || (state_d == S_WAIT);
        halted_d = (state_d == S_HALTED);
    end

    // Output and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_addr_q  <= ADDR_ZERO;
            imem_addr_q   <= ADDR_ZERO;
            instr_q       <= NOP_WORD;
            instr_valid_q <= 1'b0;
            pc_q          <= {PC_W{1'b0}};
            busy_q        <= 1'b0;
            halted_q      <= 1'b0;
            timeout_err_q <= 1'b0;
            wait_cnt_q    <= CNT_ZERO;
        end else begin
            fetch_addr_q  <= fetch_addr_d;
            imem_addr_q   <= imem_addr_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            pc_q          <= pc_d;
            busy_q        <= busy_d;
            halted_q      <= halted_d;
            timeout_err_q <= timeout_err_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    assign imem_addr_o   = imem_addr_q;
    assign instr_o       = instr_q;
    assign instr_valid_o = instr_valid_q;
    assign pc_o          = pc_q;
    assign busy_o        = busy_q;
    assign halted_o      = halted_q;
    assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_vec_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vec_instr_sequencer
//
// Runs programs (directed and random) through the sequencer. For each run a
// program interpreter computes the expected issue stream (word, address,
// cycle) and pushes it into a scoreboard queue together with the vec_done
// delay chosen for every vector op. A monitor pops and compares on every
// instr_valid; a responder answers vector ops with vec_done and sprinkles
// stray start / vec_done pulses that must be ignored.
// ---------------------------------------------------------------------------
module tb_vec_instr_sequencer;

    localparam int IW = 30;
    localparam int PW = 32;
    localparam int AW = 3;
    localparam int DEPTH = 8;
    localparam int TO = 15;

    localparam logic [3:0] OP_INCRI = 4'b0000;
    localparam logic [3:0] OP_INCRJ = 4'b0001;
    localparam logic [3:0] OP_SETN  = 4'b0010;
    localparam logic [3:0] OP_SUMFV = 4'b0011;
    localparam logic [3:0] OP_MULFV = 4'b0100;
    localparam logic [3:0] OP_HALT  = 4'b1111;
    localparam logic [IW-1:0] NOP = {4'b0101, 26'b0};

    typedef struct packed {
        logic [IW-1:0] instr;
        logic [AW-1:0] addr;
        logic [31:0]   cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_main, start_spur, vd_main, vd_drv;
    logic          start_s, vec_done_s;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_data;
    logic [IW-1:0] instr;
    logic          instr_valid;
    logic [PW-1:0] pc;
    logic          busy, halted, timeout_err;

    logic [IW-1:0] mem [DEPTH];
    exp_t          exp_q[$];
    int            done_q[$];
    int            dsched[$];
    int            tests = 0;
    int            fails = 0;

    assign start_s    = start_main | start_spur;
    assign vec_done_s = vd_main | vd_drv;

    vec_instr_sequencer #(
        .INSTR_W(IW), .PC_W(PW), .IMEM_AW(AW), .WAIT_TIMEOUT(TO)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start_s),
        .imem_addr_o(imem_addr), .imem_data_i(imem_data),
        .instr_o(instr), .instr_valid_o(instr_valid), .pc_o(pc),
        .vec_done_i(vec_done_s), .busy_o(busy), .halted_o(halted),
        .timeout_err_o(timeout_err)
    );

    always #5 clk = ~clk;

    // Synchronous program memory, one cycle read latency.
    always @(posedge clk) imem_data <= mem[imem_addr];

    // Negedges fall at 10, 20, 30 ... so this is the cycle index there.
    function automatic int now_cyc();
        return int'($time / 10);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every valid cycle must match the head of the scoreboard,
    // every other cycle must show NOP.
    exp_t mon_e;
    always @(negedge clk) begin
        if (!rst) begin
            if (instr_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_issue", {34'b0, instr}, {34'b0, NOP});
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("issue_instr", {34'b0, instr}, {34'b0, mon_e.instr});
                    chk("issue_pc", {32'b0, pc}, {61'b0, mon_e.addr});
                    chk("issue_cycle", 64'(now_cyc()), {32'b0, mon_e.cyc});
                end
            end else begin
                chk("nop_when_not_valid", {34'b0, instr}, {34'b0, NOP});
            end
        end
    end

    // Responder: answers vector ops after the scheduled delay and injects
    // stray start/vec_done pulses in FETCH or ISSUE after single-cycle ops.
    initial begin
        bit         skip;
        int         d;
        logic [3:0] op;
        skip = 1'b0;
        vd_drv = 1'b0;
        start_spur = 1'b0;
        forever begin
            if (!skip) @(negedge clk);
            skip = 1'b0;
            if (!rst && instr_valid) begin
                op = instr[IW-1 -: 4];
                if (op == OP_MULFV || op == OP_SUMFV) begin
                    if (done_q.size() > 0) begin
                        d = done_q.pop_front();
                        if (d > 0) begin
                            repeat (d - 1) @(negedge clk);
                            vd_drv = 1'b1;
                            @(negedge clk);
                            vd_drv = 1'b0;
                        end
                    end
                end else if (op != OP_HALT && $urandom_range(0, 1) == 1) begin
                    if ($urandom_range(0, 1) == 1) begin
                        vd_drv = 1'b1; start_spur = 1'b1;
                        @(negedge clk);
                        vd_drv = 1'b0; start_spur = 1'b0;
                    end else begin
                        @(negedge clk);
                        vd_drv = 1'b1; start_spur = 1'b1;
                        @(negedge clk);
                        vd_drv = 1'b0; start_spur = 1'b0;
                        skip = 1'b1;
                    end
                end
            end
        end
    end

    // Interpret the program from address 0, fill the scoreboard, pulse
    // start and wait for HALTED. Call at a negedge.
    task automatic run_prog();
        int         a, c, nw, d, halt_cyc, guard, n;
        bit         exp_err;
        logic [3:0] op;
        a = 0; c = now_cyc() + 3; nw = 0; guard = 0;
        halt_cyc = 0; exp_err = 1'b0;
        while (guard < 64) begin
            guard++;
            op = mem[a][IW-1 -: 4];
            exp_q.push_back('{instr: mem[a], addr: AW'(a), cyc: 32'(c)});
            if (op == OP_HALT) begin
                halt_cyc = c; exp_err = 1'b0;
                break;
            end
            if (op == OP_MULFV || op == OP_SUMFV) begin
                if (dsched.size() > 0)                          d = dsched.pop_front();
                else if (nw >= 3 || $urandom_range(0, 4) == 0) d = 0;
                else                                            d = $urandom_range(1, TO);
                nw++;
                done_q.push_back(d);
                if (d == 0) begin
                    halt_cyc = c + TO; exp_err = 1'b1;
                    break;
                end
                c = c + d + 2;
            end else begin
                c = c + 2;
            end
            a = (a + 1) % DEPTH;
        end
        start_main = 1'b1;
        @(negedge clk);
        start_main = 1'b0;
        chk("start_clears_err", {63'b0, timeout_err}, 64'd0);
        chk("busy_after_start", {63'b0, busy}, 64'd1);
        chk("halted_cleared", {63'b0, halted}, 64'd0);
        n = 0;
        while (!halted && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("halt_reached", {63'b0, halted}, 64'd1);
        chk("halt_cycle", 64'(now_cyc()), 64'(halt_cyc));
        chk("timeout_err", {63'b0, timeout_err}, {63'b0, exp_err});
        chk("busy_when_halted", {63'b0, busy}, 64'd0);
        @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        done_q.delete();
        dsched.delete();
    endtask

    task automatic fill(input logic [3:0] op);
        for (int i = 0; i < DEPTH; i++) mem[i] = {op, 26'(i)};
    endtask

    initial begin
        rst = 1'b1; start_main = 1'b0; vd_main = 1'b0;
        fill(OP_INCRI);
        #8;
        chk("rst_instr", {34'b0, instr}, {34'b0, NOP});
        chk("rst_valid", {63'b0, instr_valid}, 64'd0);
        chk("rst_pc", {32'b0, pc}, 64'd0);
        chk("rst_busy_halt_err", {61'b0, busy, halted, timeout_err}, 64'd0);
        chk("rst_imem_addr", {61'b0, imem_addr}, 64'd0);
        @(negedge clk); @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // SETN then HALT
        mem[0] = {OP_SETN, 26'h2000008}; mem[1] = {OP_HALT, 26'd0};
        run_prog();

        // MULFV / INCRI / HALT with a late vec_done
        mem[0] = {OP_MULFV, 26'd5}; mem[1] = {OP_INCRI, 26'd7}; mem[2] = {OP_HALT, 26'd0};
        dsched.push_back(10);
        run_prog();

        // MULFV with no vec_done: timeout, then restart refetches mem[0]
        dsched.push_back(0);
        run_prog();
        dsched.push_back(3);
        run_prog();

        // vec_done on the very cycle of the timeout: done wins
        mem[0] = {OP_SUMFV, 26'd9}; mem[1] = {OP_HALT, 26'd0};
        dsched.push_back(TO);
        run_prog();
        dsched.push_back(TO - 1);
        run_prog();

        // Address wrap: two full passes then a timed-out MULFV at the top
        fill(OP_INCRJ);
        mem[7] = {OP_MULFV, 26'd1};
        dsched.push_back(5); dsched.push_back(1); dsched.push_back(0);
        run_prog();

        // Reset while waiting on a vector op
        mem[0] = {OP_MULFV, 26'd3}; mem[1] = {OP_HALT, 26'd0};
        exp_q.push_back('{instr: mem[0], addr: 3'd0, cyc: 32'(now_cyc() + 3)});
        done_q.push_back(0);
        start_main = 1'b1;
        @(negedge clk);
        start_main = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midwait_rst_instr", {34'b0, instr}, {34'b0, NOP});
        chk("midwait_rst_busy", {63'b0, busy}, 64'd0);
        chk("midwait_rst_pc", {32'b0, pc}, 64'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        vd_main = 1'b1;
        @(negedge clk);
        vd_main = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_idle", {61'b0, busy, halted, instr_valid}, 64'd0);
        chk("post_rst_scoreboard", 64'(exp_q.size() + done_q.size()), 64'd0);
        exp_q.delete(); done_q.delete();

        // Random programs
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = {4'($urandom_range(0, 15)), 26'($urandom)};
            mem[DEPTH-1] = ($urandom_range(0, 1) == 1) ? {OP_HALT, 26'($urandom)}
                                                      : {OP_MULFV, 26'($urandom)};
            run_prog();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute watchdog so the bench can never hang.
    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish, got running, expected done");
        $fatal(1, "global timeout");
    end

endmodule
